// File: rtl/instr_pkg.sv
// Shared instruction-format definitions: format enum, fixed opcodes and the
// MIPS field bit positions used by both the encoder and the decoder block.
package instr_pkg;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_ILL = 2'd3
  } fmt_e;

  localparam logic [5:0] OP_RTYPE = 6'h0;
  localparam logic [5:0] OP_J     = 6'h2;
  localparam logic [5:0] OP_JAL   = 6'h3;

  localparam int OP_LSB     = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_LSB = 0;

  function automatic logic is_jump_op(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy counter; rdata reads zero while empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rptr];

  // Storage is left unreset: the empty gate on rdata hides stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes R/I/J instruction fields into 32-bit MIPS words, drops illegal
// requests, queues legal words and keeps per-class encode counters.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_fmt,
  input  logic [5:0]       in_op,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_shamt,
  input  logic [5:0]       in_funct,
  input  logic [15:0]      in_imm,
  input  logic [25:0]      in_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_word,
  output logic [CNT_W-1:0] R_counter,
  output logic [CNT_W-1:0] I_counter,
  output logic [CNT_W-1:0] J_counter,
  output logic [CNT_W-1:0] err_counter
);

  fmt_e        fmt;
  logic [31:0] enc;
  logic        legal, accept, full, empty;

  assign fmt    = fmt_e'(in_fmt);
  assign accept = in_valid && in_ready;

  always_comb begin
    enc   = '0;
    legal = 1'b0;
    case (fmt)
      FMT_R: begin
        enc[OP_LSB +: 6]    = OP_RTYPE;
        enc[RS_LSB +: 5]    = in_rs;
        enc[RT_LSB +: 5]    = in_rt;
        enc[RD_LSB +: 5]    = in_rd;
        enc[SHAMT_LSB +: 5] = in_shamt;
        enc[FUNCT_LSB +: 6] = in_funct;
        legal               = 1'b1;
      end
      FMT_I: begin
        enc[OP_LSB +: 6]   = in_op;
        enc[RS_LSB +: 5]   = in_rs;
        enc[RT_LSB +: 5]   = in_rt;
        enc[IMM_LSB +: 16] = in_imm;
        legal              = (in_op != OP_RTYPE) && !is_jump_op(in_op);
      end
      FMT_J: begin
        enc[OP_LSB +: 6]      = in_op;
        enc[TARGET_LSB +: 26] = in_target;
        legal                 = is_jump_op(in_op);
      end
      default: ;
    endcase
  end

  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept && legal),
    .wdata (enc),
    .pop   (out_ready),
    .rdata (out_word),
    .full  (full),
    .empty (empty)
  );

  assign in_ready  = !full;
  assign out_valid = !empty;

  // Class counters wrap; the error counter sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R_counter   <= '0;
      I_counter   <= '0;
      J_counter   <= '0;
      err_counter <= '0;
    end else if (accept) begin
      if (!legal) begin
        if (err_counter != '1) err_counter <= err_counter + CNT_W'(1);
      end else begin
        case (fmt)
          FMT_R:   R_counter <= R_counter + CNT_W'(1);
          FMT_I:   I_counter <= I_counter + CNT_W'(1);
          FMT_J:   J_counter <= J_counter + CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus random traffic, all
// checked against a queue-based reference model.
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [1:0]       in_fmt;
  logic [5:0]       in_op, in_funct;
  logic [4:0]       in_rs, in_rt, in_rd, in_shamt;
  logic [15:0]      in_imm;
  logic [25:0]      in_target;
  logic [31:0]      out_word;
  logic [CNT_W-1:0] R_counter, I_counter, J_counter, err_counter;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mq[$];
  int mr, mi, mj, me;

  instr_encoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .R_counter(R_counter), .I_counter(I_counter), .J_counter(J_counter),
    .err_counter(err_counter)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference encoding written as plain arithmetic on the MIPS field layout.
  function automatic void ref_enc(output bit legal, output logic [31:0] w);
    int f = int'(in_fmt);
    int op = int'(in_op);
    legal = 0;
    w = 0;
    if (f == 0) begin
      w = (in_rs << 21) + (in_rt << 16) + (in_rd << 11) + (in_shamt << 6) + in_funct;
      legal = 1;
    end else if (f == 1) begin
      w = (op * 32'h0400_0000) + (in_rs << 21) + (in_rt << 16) + in_imm;
      legal = (op > 3) || (op == 1);
    end else if (f == 2) begin
      w = (op * 32'h0400_0000) + in_target;
      legal = (op == 2) || (op == 3);
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    chk({tag, ".out_word"},  out_word, (mq.size() != 0) ? mq[0] : 32'h0);
    chk({tag, ".in_ready"},  32'(in_ready), 32'(mq.size() < DEPTH));
    chk({tag, ".R_cnt"},     32'(R_counter), 32'(mr));
    chk({tag, ".I_cnt"},     32'(I_counter), 32'(mi));
    chk({tag, ".J_cnt"},     32'(J_counter), 32'(mj));
    chk({tag, ".err_cnt"},   32'(err_counter), 32'(me));
  endtask

  // Called just after a falling edge with inputs set; advances one clock.
  task automatic cycle(input string tag);
    bit legal, acc, pop;
    logic [31:0] w;
    int f = int'(in_fmt);
    ref_enc(legal, w);
    acc = in_valid && (mq.size() < DEPTH);
    pop = (mq.size() != 0) && out_ready;
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (acc) begin
      if (!legal) me = (me < CMAX) ? me + 1 : CMAX;
      else begin
        mq.push_back(w);
        if (f == 0) mr = (mr + 1) % (CMAX + 1);
        if (f == 1) mi = (mi + 1) % (CMAX + 1);
        if (f == 2) mj = (mj + 1) % (CMAX + 1);
      end
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic set_req(input logic v, input logic [1:0] f, input logic [5:0] op,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [4:0] sh, input logic [5:0] fn, input logic [15:0] imm,
                         input logic [25:0] tgt);
    in_valid = v; in_fmt = f; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_funct = fn; in_imm = imm; in_target = tgt;
  endtask

  task automatic idle();
    set_req(1'b0, 2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
  endtask

  task automatic model_reset();
    mq.delete();
    mr = 0; mi = 0; mj = 0; me = 0;
  endtask

  initial begin
    logic [31:0] held;
    model_reset();
    idle();
    out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check_all("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    check_all("post_reset");

    // R encode; out_ready low so the word is observable for a cycle.
    out_ready = 1'b0;
    set_req(1'b1, 2'd0, 6'h3f, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0);
    cycle("r_enc");
    chk("r_word", out_word, 32'h0022_1820);
    chk("r_count", 32'(R_counter), 32'd1);
    idle(); out_ready = 1'b1;
    cycle("r_drain");

    set_req(1'b1, 2'd1, 6'h08, 5'd1, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0);
    out_ready = 1'b0;
    cycle("i_enc");
    chk("i_word", out_word, 32'h2024_0005);
    chk("i_count", 32'(I_counter), 32'd1);
    idle(); out_ready = 1'b1;
    cycle("i_drain");

    set_req(1'b1, 2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h010_0000);
    out_ready = 1'b0;
    cycle("j_enc");
    chk("j_word", out_word, 32'h0810_0000);
    chk("j_count", 32'(J_counter), 32'd1);
    idle(); out_ready = 1'b1;
    cycle("j_drain");

    // Illegal requests: I with a jump opcode, then format 3.
    set_req(1'b1, 2'd1, 6'h02, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0);
    cycle("ill_i");
    set_req(1'b1, 2'd3, 6'h08, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1, 26'd1);
    cycle("ill_fmt");
    chk("ill_valid", 32'(out_valid), 32'd0);
    chk("ill_err", 32'(err_counter), 32'd2);
    chk("ill_ready", 32'(in_ready), 32'd1);
    idle();

    // Backpressure: four fill the queue, the fifth waits for space.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_req(1'b1, 2'd1, 6'h09, 5'(k), 5'(k + 1), 5'd0, 5'd0, 6'd0, 16'(100 + k), 26'd0);
      cycle("bp_fill");
    end
    chk("bp_full", 32'(in_ready), 32'd0);
    set_req(1'b1, 2'd1, 6'h09, 5'd7, 5'd8, 5'd0, 5'd0, 6'd0, 16'd104, 26'd0);
    held = out_word;
    for (int k = 0; k < 3; k++) begin
      cycle("bp_stall");
      chk("bp_stable", out_word, held);
    end
    chk("bp_cnt_held", 32'(I_counter), 32'(mi));
    out_ready = 1'b1;
    begin
      int budget = 20;
      while (in_valid && budget > 0) begin
        if (mq.size() < DEPTH) begin cycle("bp_take5"); idle(); end
        else cycle("bp_wait");
        budget--;
      end
      chk("bp_5th_accepted", 32'(in_valid), 32'd0);
      budget = 20;
      while (mq.size() != 0 && budget > 0) begin cycle("bp_drain"); budget--; end
      chk("bp_drained", 32'(mq.size()), 32'd0);
    end

    // Reset mid-cycle with two words queued.
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_req(1'b1, 2'd0, 6'd0, 5'(k), 5'd1, 5'd2, 5'd3, 6'h21, 16'd0, 26'd0);
      cycle("rst_fill");
    end
    idle();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) cycle("post_rst_idle");

    // Counter wrap: eight R requests bring R_counter back to 0.
    for (int k = 0; k < 8; k++) begin
      set_req(1'b1, 2'd0, 6'd0, 5'(k), 5'(k), 5'(k), 5'd0, 6'h20, 16'd0, 26'd0);
      cycle("wrap");
    end
    chk("wrap_r_zero", 32'(R_counter), 32'd0);
    idle();
    cycle("wrap_idle");

    // Random traffic; enough illegal requests to saturate err_counter.
    for (int k = 0; k < 600; k++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 3)) : 6'($urandom);
      set_req(1'($urandom_range(0, 3) != 0), 2'($urandom), op, 5'($urandom), 5'($urandom),
              5'($urandom), 5'($urandom), 6'($urandom), 16'($urandom), 26'($urandom));
      out_ready = 1'($urandom_range(0, 2) != 0);
      cycle("rand");
    end
    chk("err_saturated", 32'(err_counter), 32'(CMAX));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
